// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte producers.
// Latency: req seen in IDLE -> grant/tx_start next cycle; tx_done (or rx_done) -> done next cycle.
// Backpressure: requesters hold req until their grant pulse; one transaction in flight at a time.
//
// Optional feature macro: UART_ARB_LOOPBACK_CHECK_EN adds a WAIT_RX state that compares
// the looped-back receiver byte with the transmitted one. When it is not defined, the
// rx inputs are ignored and o_err_mismatch stays 0.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req, i_req_data   per-requester level request and byte (byte i at [8i+7:8i])
//   o_grant, o_done     one-hot pulses: byte accepted / byte fully sent
//   o_tx_data, o_tx_start, i_tx_done   UART transmitter handshake
//   i_rx_data, i_rx_done               UART receiver (loopback check only)
//   o_busy              high whenever not IDLE
//   o_err_timeout, o_err_mismatch, o_err_id   error pulses and sticky requester index
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_done,
  output logic                   o_busy,
  output logic                   o_err_timeout,
  output logic                   o_err_mismatch,
  output logic [2:0]             o_err_id
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_RST = 3'(NUM_REQ - 1);

`ifdef UART_ARB_LOOPBACK_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_TX = 2'd2,
    S_WAIT_RX = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_TX = 2'd2
  } state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         r_last;
  logic [7:0]         r_tx_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err_timeout;
  logic               r_err_mismatch;
  logic [2:0]         r_err_id;

  logic               w_sel_vld;
  logic [2:0]         w_sel_idx;
  logic [7:0]         w_sel_byte;
  logic [NUM_REQ-1:0] w_idx_oh;
  logic               w_load;
  logic               w_cnt_clr;
  logic               w_waiting;
  logic               w_finish;
  logic               w_tout;
  logic               w_mis;

`ifndef UART_ARB_LOOPBACK_CHECK_EN
  // Receiver inputs have no function without the loopback check.
  logic w_unused_rx;
  assign w_unused_rx = ^{i_rx_data, i_rx_done};
`endif

  // Round-robin pick: distance k=1 is the requester right after the last one served.
  // Walking k downward lets the nearest requesting index overwrite farther ones.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_idx  = 3'd0;
    w_sel_byte = 8'h00;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int b = 0; b < NUM_REQ; b++) begin
        if (i_req[b] && (((int'(r_last) + k) % NUM_REQ) == b)) begin
          w_sel_vld  = 1'b1;
          w_sel_idx  = 3'(b);
          w_sel_byte = i_req_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_idx_oh = '0;
    for (int b = 0; b < NUM_REQ; b++) begin
      w_idx_oh[b] = (r_idx == 3'(b));
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_waiting   = 1'b0;
    w_finish    = 1'b0;
    w_tout      = 1'b0;
    w_mis       = 1'b0;
    o_grant     = '0;
    o_tx_start  = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        o_grant     = w_idx_oh;
        o_tx_start  = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        w_waiting = 1'b1;
        // tx_done takes priority over a timeout expiring in the same cycle.
        if (i_tx_done) begin
`ifdef UART_ARB_LOOPBACK_CHECK_EN
          // The receive wait gets its own full timeout budget.
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_WAIT_RX;
`else
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end else if (r_cnt == CNT_LAST) begin
          w_tout      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef UART_ARB_LOOPBACK_CHECK_EN
      S_WAIT_RX: begin
        w_waiting = 1'b1;
        if (i_rx_done) begin
          w_finish    = 1'b1;
          w_mis       = (i_rx_data != r_tx_data);
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_tout      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_idx          <= 3'd0;
      r_last         <= LAST_RST;
      r_tx_data      <= 8'h00;
      r_cnt          <= '0;
      r_done         <= '0;
      r_err_timeout  <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_id       <= 3'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_done         <= w_finish ? w_idx_oh : '0;
      r_err_timeout  <= w_tout;
      r_err_mismatch <= w_mis;
      if (w_tout || w_mis) begin
        r_err_id <= r_idx;
      end
      if (w_load) begin
        r_idx     <= w_sel_idx;
        r_last    <= w_sel_idx;
        r_tx_data <= w_sel_byte;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_waiting) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_done         = r_done;
  assign o_tx_data      = r_tx_data;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_mismatch = r_err_mismatch;
  assign o_err_id       = r_err_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized requesters and a UART stub,
// all checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant, done;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_done = 1'b0;
  logic           busy, err_timeout, err_mismatch;
  logic [2:0]     err_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_data(req_data),
    .o_grant(grant), .o_done(done), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_done(tx_done), .i_rx_data(rx_data), .i_rx_done(rx_done), .o_busy(busy),
    .o_err_timeout(err_timeout), .o_err_mismatch(err_mismatch), .o_err_id(err_id)
  );

  logic [7:0] bytes [N];
  assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

  int n_cmp = 0, n_mis = 0, spurious = 0;
  int n_grant = 0, n_done = 0, n_tout = 0, n_mism = 0;
  int grant_log[$];

  // model / stimulus state
  logic [N-1:0] pending = '0;
  int           model_last = N - 1;
  bit           act = 0, exp_done_now = 0, exp_mis_now = 0;
  int           act_idx = 0;
  logic [7:0]   act_byte = 8'h00;
  int           tx_cnt = 0, rx_cnt = 0, tout_cnt = 0;
  bit           idle_prev = 0, reset_prev = 1;
  logic [N-1:0] req_prev = '0;
  bit           rand_en = 0, drop_en = 1, stuck = 0, rst_req = 1, rand_corrupt = 0;
  int           forced_delay = 0;
  logic [7:0]   corrupt_mask = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next requester after 'last' in circular order that is requesting.
  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One clock: observe at negedge, check against the model, then drive the next cycle.
  task automatic step();
    int e;
    @(negedge clk);
    if (reset_prev) begin
      chk("rst_quiet", {grant, done, tx_start, busy, err_timeout, err_mismatch}, 0);
      act = 0; tx_cnt = 0; rx_cnt = 0; tout_cnt = 0;
      exp_done_now = 0; exp_mis_now = 0; model_last = N - 1;
    end else begin
      if (exp_done_now) begin
        chk("done", done, onehot(act_idx));
        chk("busy_fall", busy, 0);
        chk("err_mismatch", err_mismatch, exp_mis_now);
        if (exp_mis_now) chk("err_id_mis", err_id, act_idx);
        n_done++;
        if (exp_mis_now) n_mism++;
      end else begin
        if (done != 0) spurious++;
        if (err_mismatch) spurious++;
      end
      if (tout_cnt > 0) begin
        tout_cnt--;
        if (tout_cnt == 0) begin
          chk("err_timeout", err_timeout, 1);
          chk("err_id_tout", err_id, act_idx);
          chk("busy_tout", busy, 0);
          n_tout++;
          act = 0;
        end else if (err_timeout) spurious++;
      end else if (err_timeout) spurious++;
      if (idle_prev && req_prev != 0) begin
        e = rr(req_prev, model_last);
        chk("grant", grant, onehot(e));
        chk("tx_start", tx_start, 1);
        chk("tx_data", tx_data, bytes[e]);
        chk("busy_rise", busy, 1);
        model_last = e; act = 1; act_idx = e; act_byte = bytes[e];
        grant_log.push_back(e);
        n_grant++;
        tx_cnt   = stuck ? 0 : ((forced_delay > 0 ? forced_delay : $urandom_range(8, 1)) + 1);
        tout_cnt = stuck ? TMO + 1 : 0;
        if (rand_corrupt)
          corrupt_mask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      end else if (tx_start || grant != 0) spurious++;
    end
    exp_done_now = 0;
    exp_mis_now  = 0;
    // requesters
    if (drop_en) pending = pending & ~grant;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(7, 0) == 0) begin
          bytes[i]   = 8'($urandom);
          pending[i] = 1'b1;
        end
      end
    end
    // UART stub
    tx_done = 1'b0;
    rx_done = 1'b0;
    if (act && tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
`ifdef UART_ARB_LOOPBACK_CHECK_EN
        rx_cnt = $urandom_range(4, 1);
`else
        exp_done_now = 1;
        act = 0;
`endif
      end
    end
`ifdef UART_ARB_LOOPBACK_CHECK_EN
    else if (act && rx_cnt > 0) begin
      rx_cnt--;
      if (rx_cnt == 0) begin
        rx_done      = 1'b1;
        rx_data      = act_byte ^ corrupt_mask;
        exp_done_now = 1;
        exp_mis_now  = (corrupt_mask != 8'h00);
        act          = 0;
      end
    end
`endif
    else if (!act && rand_en) begin
      // stale pulses outside a transaction must be ignored
      tx_done = ($urandom_range(5, 0) == 0);
      rx_done = ($urandom_range(5, 0) == 0);
      rx_data = 8'($urandom);
    end
    reset      = rst_req;
    reset_prev = rst_req;
    req        = pending;
    req_prev   = pending;
    idle_prev  = !busy;
  endtask

  task automatic do_reset(input int n);
    rst_req = 1;
    repeat (n) step();
    rst_req = 0;
  endtask

  task automatic run_until_grants(input int target, input int bound);
    int t;
    t = 0;
    while (n_grant < target && t < bound) begin
      step();
      t++;
    end
    chk("grant_wait_bound", (n_grant >= target), 1);
  endtask

  task automatic wait_quiet(input int bound);
    int t;
    t = 0;
    while ((act || exp_done_now || tout_cnt > 0 || pending != 0) && t < bound) begin
      step();
      t++;
    end
    chk("quiet_bound", (!act && !exp_done_now && tout_cnt == 0 && pending == 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, t0, m0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) bytes[i] = 8'h00;

    // reset held 10 cycles, then idle with no requests
    do_reset(10);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_err_id", err_id, 0);
    repeat (10) step();
    chk("idle_outs", {grant, done, tx_start, busy, err_timeout, err_mismatch, tx_data}, 0);

    // single request from requester 0
    d0 = n_done;
    bytes[0] = 8'h55;
    pending  = 4'b0001;
    wait_quiet(100);
    chk("single_grant_idx", grant_log[grant_log.size()-1], 0);
    chk("single_done_cnt", n_done, d0 + 1);

    // all four held: strict rotation 0,1,2,3,0
    do_reset(2);
    drop_en = 0;
    for (int i = 0; i < N; i++) bytes[i] = 8'hA0 + 8'(i);
    pending = 4'b1111;
    g0 = n_grant;
    run_until_grants(g0 + 5, 400);
    pending = 4'b0000;
    drop_en = 1;
    wait_quiet(100);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), grant_log[g0 + i], exp_order[i]);

    // tx_done never arrives: timeout exactly TMO cycles after WAIT_TX entry
    do_reset(2);
    d0 = n_done; t0 = n_tout;
    stuck    = 1;
    bytes[2] = 8'h3C;
    pending  = 4'b0100;
    wait_quiet(200);
    stuck = 0;
    chk("tout_cnt", n_tout, t0 + 1);
    chk("tout_no_done", n_done, d0);
    chk("tout_err_id", err_id, 2);

    // tx_done on the very cycle the timeout would expire: done wins
    d0 = n_done; t0 = n_tout;
    forced_delay = TMO;
    bytes[1] = 8'h96;
    pending  = 4'b0010;
    wait_quiet(200);
    forced_delay = 0;
    chk("edge_done", n_done, d0 + 1);
    chk("edge_no_tout", n_tout, t0);

`ifdef UART_ARB_LOOPBACK_CHECK_EN
    // loopback returns a corrupted byte
    do_reset(2);
    m0 = n_mism;
    corrupt_mask = 8'hFF;
    bytes[0] = 8'h55;
    pending  = 4'b0001;
    wait_quiet(100);
    corrupt_mask = 8'h00;
    chk("mismatch_cnt", n_mism, m0 + 1);
`else
    m0 = 0;
`endif

    // reset in the middle of WAIT_TX for requester 2
    do_reset(2);
    d0 = n_done;
    stuck    = 1;
    bytes[2] = 8'h21;
    pending  = 4'b0100;
    g0 = n_grant;
    run_until_grants(g0 + 1, 20);
    repeat (3) step();
    rst_req = 1;
    step();
    rst_req  = 0;
    stuck    = 0;
    bytes[0] = 8'h12;
    pending  = 4'b0101;
    step();
    chk("midrst_no_done", n_done, d0);
    g0 = n_grant;
    run_until_grants(g0 + 1, 20);
    chk("midrst_first_idx", grant_log[grant_log.size()-1], 0);
    wait_quiet(200);

    // randomized traffic with stale pulses
    do_reset(2);
    g0 = n_grant;
    rand_en = 1;
`ifdef UART_ARB_LOOPBACK_CHECK_EN
    rand_corrupt = 1;
`endif
    repeat (2500) step();
    rand_en      = 0;
    rand_corrupt = 0;
    wait_quiet(300);
    chk("rand_activity", (n_grant - g0 > 50), 1);
    chk("spurious", spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one UART transmitter (`tx_data`/`tx_start`/`tx_done`) between `NUM_REQ` byte producers. It sits directly in front of the UART top-level: it picks a requester, loads its byte, pulses `tx_start`, waits for `tx_done`, and reports per-requester completion or timeout. An optional loopback self-check compares the received byte against the transmitted one.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 200000: max `clk` cycles spent waiting in WAIT_TX or WAIT_RX before abort; ≥ 16.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester level request; held until `grant` bit seen.
- `req_data`  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]; stable while `req[i]` high.
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse: requester i's byte fully sent (and checked, if enabled).
- `tx_data`  out  8  byte to UART transmitter; held for the whole transaction.
- `tx_start`  out  1  one-cycle start pulse to UART transmitter.
- `tx_done`  in  1  transmitter completion pulse.
- `rx_data`  in  8  UART receiver byte (used only with check enabled).
- `rx_done`  in  1  receiver completion pulse (used only with check enabled).
- `busy`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  one-cycle pulse on timeout abort.
- `err_mismatch`  out  1  one-cycle pulse on loopback mismatch (0 when check disabled).
- `err_id`  out  3  index of requester associated with the last error pulse; holds value.

## Operation
- States: IDLE, START, WAIT_TX, WAIT_RX (check builds only).
- IDLE: if `req` ≠ 0, select first set bit searching upward from `last+1` (wrapping modulo NUM_REQ); latch index and byte into `tx_data`; go START. `last` := selected index.
- START: `grant[idx]`=1 and `tx_start`=1 for exactly this cycle; clear timeout counter; go WAIT_TX.
- WAIT_TX: `tx_done` sampled only in this state (earlier/stale pulses ignored). On `tx_done`: go WAIT_RX if check enabled, else pulse `done[idx]` next cycle and return IDLE.
- WAIT_RX: on `rx_done`, compare `rx_data` with latched byte; mismatch → `err_mismatch` pulse, `err_id`:=idx. `done[idx]` pulses in both cases; return IDLE.
- Timeout: counter increments each cycle in WAIT_TX/WAIT_RX; on reaching `TIMEOUT_CYCLES` → `err_timeout` pulse, `err_id`:=idx, no `done`, return IDLE.
- `req[i]` dropped before selection: no grant. `req[i]` still high after its `done`: eligible again, but round-robin serves other pending requesters first.
- Simultaneous `tx_done` and timeout expiry in same cycle: `tx_done` wins.
- Reset value of all outputs 0; `tx_data`=8'h00; `last`=NUM_REQ-1 (requester 0 wins the first contention); state IDLE.
- Reset mid-transaction: abort immediately, `tx_start` low, no `done`/error pulse; UART must be reset by the same `reset`.

## Timing
- `req` high in cycle N (IDLE) → `grant`/`tx_start` in cycle N+1.
- `tx_done` in cycle M → `done` in cycle M+1 (check disabled); `rx_done` in cycle R → `done`/`err_mismatch` in R+1 (check enabled).
- Back-to-back: next selection in the cycle after `done`; minimum 3 idle-path cycles between consecutive `tx_start` pulses plus UART frame time.
- `busy` registered, rises in cycle N+1, falls the cycle `done`/`err_timeout` pulses.

## Configuration
- `UART_ARB_LOOPBACK_CHECK_EN` defined: WAIT_RX present; `rx_data`/`rx_done` compared as above; `err_mismatch` live.
- Undefined: WAIT_RX removed, `rx_*` inputs ignored, `err_mismatch` tied 0, `done` follows `tx_done`.

## Test plan
- Reset held 10 cycles, then `req`=4'b0000 → all outputs 0, `busy`=0, `tx_start` never pulses.
- `req`=4'b0001, byte0=8'h55, UART loopback → `grant`=4'b0001 and `tx_start` next cycle, `tx_data`=8'h55, `done`=4'b0001 after frame; with check, `rx_data`=8'h55 and no `err_mismatch`.
- `req`=4'b1111 held, bytes 8'hA0..8'hA3 → grants in order 0,1,2,3,0; each `done` precedes the next `tx_start`.
- `tx_done` tied 0, `TIMEOUT_CYCLES`=64 → `err_timeout` pulse exactly 64 cycles after WAIT_TX entry, `err_id`=granted index, no `done`.
- Check enabled, receiver stub returns 8'hAA for sent 8'h55 → `err_mismatch`=1, `err_id`=0, `done`=4'b0001 same cycle.
- `reset` asserted during WAIT_TX for requester 2 → next cycle state IDLE, `busy`=0, no `done`; after release requester 0 wins first.
